// File: rtl/pwm_output_stage.sv
// PWM output stage: prescaled 255-count period, slew-limited duty updated once per period,
// registered waveform and period-start marker.
module pwm_output_stage #(
    parameter int PRESCALE  = 4,
    parameter int SLEW_STEP = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] duty_in,
    output logic       pwm_out,
    output logic       period_start,
    output logic [7:0] duty_active
);

    localparam int              PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PRE_MAX = PW'(PRESCALE - 1);
    localparam int              STEP_C  = (SLEW_STEP > 255) ? 255 : SLEW_STEP;
    localparam logic signed [9:0] STEP  = 10'(STEP_C);
    localparam logic [7:0]      STEP8   = 8'(STEP_C);
    localparam logic [7:0]      CNT_MAX = 8'd254;

    logic [PW-1:0]      pre_q, pre_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [7:0]         duty_q, duty_d, duty_slew;
    logic               pwm_q, pwm_d;
    logic               ps_q, ps_d;
    logic               tick, bnd;
    logic signed [9:0]  diff;

    assign tick = (pre_q == PRE_MAX);
    assign bnd  = enable && tick && (cnt_q == CNT_MAX);

    // Widened so the difference can never wrap; a step is only taken when
    // |diff| > STEP, which keeps the result inside 0..255.
    assign diff = $signed({2'b00, duty_in}) - $signed({2'b00, duty_q});

    always_comb begin
        duty_slew = duty_in;
        if (SLEW_STEP != 0) begin
            if (diff > STEP)
                duty_slew = duty_q + STEP8;
            else if (diff < -STEP)
                duty_slew = duty_q - STEP8;
        end
    end

    always_comb begin
        pre_d  = '0;
        cnt_d  = '0;
        duty_d = '0;
        if (enable) begin
            pre_d  = tick ? '0 : pre_q + PW'(1);
            cnt_d  = cnt_q;
            duty_d = duty_q;
            if (tick)
                cnt_d = (cnt_q == CNT_MAX) ? 8'd0 : cnt_q + 8'd1;
            if (bnd)
                duty_d = duty_slew;
        end
    end

    // Outputs are registered from the pre-edge counter state.
    assign pwm_d = enable && (cnt_q < duty_q);
    assign ps_d  = enable && (cnt_q == 8'd0) && (pre_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q  <= '0;
            cnt_q  <= '0;
            duty_q <= '0;
            pwm_q  <= 1'b0;
            ps_q   <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
            ps_q   <= ps_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = ps_q;
    assign duty_active  = duty_q;

endmodule

// File: tb/tb_pwm_output_stage.sv
// Scoreboard bench: expected duty per period is queued with the stimulus and checked at each
// period_start, along with the previous period's length and high-time.
module tb_pwm_output_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_a, en_b;
    logic [7:0] duty_in_a, duty_in_b;
    logic       pwm_a, pwm_b, ps_a, ps_b;
    logic [7:0] duty_a, duty_b;

    int vectors = 0;
    int miscompares = 0;

    int qa[$];
    int qb[$];

    always #5 clk = ~clk;

    pwm_output_stage #(.PRESCALE(1), .SLEW_STEP(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .duty_in(duty_in_a),
        .pwm_out(pwm_a), .period_start(ps_a), .duty_active(duty_a));

    pwm_output_stage #(.PRESCALE(4), .SLEW_STEP(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .duty_in(duty_in_b),
        .pwm_out(pwm_b), .period_start(ps_b), .duty_active(duty_b));

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor for DUT A (period 255 clk)
    bit a_started = 0;
    int a_len = 0, a_hi = 0, a_prev = 0;
    always @(negedge clk) begin
        if (!rst_n || !en_a) begin
            a_started = 0;
        end else begin
            if (ps_a) begin
                if (a_started) begin
                    chk("A_period_len", a_len, 255);
                    chk("A_high_width", a_hi, a_prev);
                end
                if (qa.size() > 0) chk("A_duty_active", duty_a, qa.pop_front());
                a_prev = duty_a;
                a_len = 0;
                a_hi = 0;
                a_started = 1;
            end
            a_len++;
            if (pwm_a) a_hi++;
        end
    end

    // Monitor for DUT B (period 1020 clk)
    bit b_started = 0;
    int b_len = 0, b_hi = 0, b_prev = 0;
    always @(negedge clk) begin
        if (!rst_n || !en_b) begin
            b_started = 0;
        end else begin
            if (ps_b) begin
                if (b_started) begin
                    chk("B_period_len", b_len, 1020);
                    chk("B_high_width", b_hi, b_prev * 4);
                end
                if (qb.size() > 0) chk("B_duty_active", duty_b, qb.pop_front());
                b_prev = duty_b;
                b_len = 0;
                b_hi = 0;
                b_started = 1;
            end
            b_len++;
            if (pwm_b) b_hi++;
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input bit which, input int budget);
        int left;
        left = which ? qb.size() : qa.size();
        for (int i = 0; i < budget && left > 0; i++) begin
            step(1);
            left = which ? qb.size() : qa.size();
        end
        if (left > 0) begin
            chk(which ? "B_drain_timeout" : "A_drain_timeout", left, 0);
            if (which) qb.delete(); else qa.delete();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en_a = 1'b0; en_b = 1'b0;
        duty_in_a = 8'd0; duty_in_b = 8'd0;
        #3;
        chk("rst_pwm_a", pwm_a, 0);
        chk("rst_ps_a", ps_a, 0);
        chk("rst_duty_a", duty_a, 0);
        chk("rst_pwm_b", pwm_b, 0);
        chk("rst_ps_b", ps_b, 0);
        chk("rst_duty_b", duty_b, 0);
        step(2);
        rst_n = 1'b1;
        step(2);

        // 50% duty, unlimited slew
        duty_in_a = 8'd128; en_a = 1'b1;
        qa.push_back(0); qa.push_back(128); qa.push_back(128);
        drain(0, 4 * 255);

        // Full scale, then zero
        duty_in_a = 8'd255;
        qa.push_back(255); qa.push_back(255);
        drain(0, 3 * 255);
        duty_in_a = 8'd0;
        qa.push_back(0); qa.push_back(0);
        drain(0, 3 * 255);

        // Mid-period duty change is deferred to the boundary
        duty_in_a = 8'd100;
        qa.push_back(100);
        drain(0, 2 * 255);
        step(49);
        duty_in_a = 8'd200;
        chk("A_hold_mid_period", duty_a, 100);
        qa.push_back(200);
        drain(0, 2 * 255);

        // Disable mid-period, then re-enable
        duty_in_a = 8'd100;
        qa.push_back(100);
        drain(0, 2 * 255);
        step(119);
        en_a = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("A_dis_pwm", pwm_a, 0);
        chk("A_dis_duty", duty_a, 0);
        chk("A_dis_ps", ps_a, 0);
        step(5);
        qa.push_back(0); qa.push_back(100);
        en_a = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("A_reen_ps", ps_a, 1);
        drain(0, 3 * 255);

        // Asynchronous reset mid-period
        duty_in_a = 8'd128;
        step(199);
        #2;
        rst_n = 1'b0;
        #1;
        chk("A_arst_pwm", pwm_a, 0);
        chk("A_arst_ps", ps_a, 0);
        chk("A_arst_duty", duty_a, 0);
        step(3);
        qa.push_back(0); qa.push_back(128); qa.push_back(128);
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("A_rel_ps", ps_a, 1);
        drain(0, 4 * 255);
        en_a = 1'b0;
        step(2);

        // Slew-limited ramp up and down
        duty_in_b = 8'd40; en_b = 1'b1;
        qb.push_back(0);  qb.push_back(8);  qb.push_back(16); qb.push_back(24);
        qb.push_back(32); qb.push_back(40); qb.push_back(40);
        drain(1, 8 * 1020);
        duty_in_b = 8'd0;
        qb.push_back(32); qb.push_back(24); qb.push_back(16);
        qb.push_back(8);  qb.push_back(0);  qb.push_back(0);
        drain(1, 7 * 1020);
        en_b = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pwm_output_stage.md
PWM_OUTPUT_STAGE -- requirements
Module: pwm_output_stage

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 4: clk cycles per PWM count, legal range 1..256.
REQ-002 The block SHALL have parameter SLEW_STEP, default 8: max duty change per period; 0 means unlimited.
REQ-003 Port clk, input, 1 bit: the system clock; all state SHALL change on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous, active-low; clock clk.
REQ-005 Port enable, input, 1 bit: run/stop control.
REQ-006 Port duty_in, input, 8 bits: requested duty, unsigned, driven by the PID controller's control_out.
REQ-007 Port pwm_out, output, 1 bit: registered PWM waveform.
REQ-008 Port period_start, output, 1 bit: registered one-cycle pulse marking the first count of each period.
REQ-009 Port duty_active, output, 8 bits: duty value currently applied.

Function
REQ-010 A prescaler pre SHALL count 0..PRESCALE-1 and wrap to 0; a tick occurs when pre == PRESCALE-1.
REQ-011 A period counter cnt SHALL count 0..254 and advance by 1 only on a tick, wrapping 254 -> 0, giving a period of 255*PRESCALE clk cycles.
REQ-012 A boundary event B SHALL be defined as enable=1, cnt=254 and a tick in the same cycle.
REQ-013 duty_active SHALL change only at B, on the same clock edge on which cnt wraps to 0.
REQ-014 At B, the difference SHALL be computed with 9-bit signed arithmetic (no wrap), with d = duty_in - duty_active.
REQ-015 If SLEW_STEP=0 or |d| <= SLEW_STEP, duty_active SHALL become duty_in.
REQ-016 If d > SLEW_STEP, duty_active SHALL increase by SLEW_STEP.
REQ-017 If d < -SLEW_STEP, duty_active SHALL decrease by SLEW_STEP.
REQ-018 The slew result SHALL never leave the range 0..255.
REQ-019 Changes on duty_in between boundaries SHALL be ignored; only the value sampled at B matters.
REQ-020 pwm_out SHALL be registered with value enable && (cnt < duty_active), evaluated on the pre-edge state; this is 1 clk latency from counter state.
REQ-021 As a result of REQ-020, duty_active=0 SHALL give pwm_out constantly 0, and duty_active=255 SHALL give pwm_out constantly 1 while running.
REQ-022 period_start SHALL be registered with value enable && cnt==0 && pre==0, so it is high for exactly 1 clk per period.
REQ-023 While enable=0, pre and cnt SHALL be held at 0.
REQ-024 While enable=0, duty_active SHALL be cleared to 0 (soft start on re-enable).
REQ-025 While enable=0, pwm_out and period_start SHALL be 0 from the next edge onward.
REQ-026 On an enable rise, counting SHALL start from cnt=0, pre=0.
REQ-027 On an enable rise, period_start SHALL pulse on the following edge.
REQ-028 On an enable rise, the first period SHALL be fully low, because duty_active=0 until the first B.
REQ-029 If enable falls in the same cycle as B, the disable SHALL take priority: duty_active is not updated and is cleared to 0.

Reset
REQ-030 On rst_n low, pre, cnt and duty_active SHALL go to 0 immediately, without waiting for a clk edge.
REQ-031 On rst_n low, pwm_out and period_start SHALL go to 0 immediately, without waiting for a clk edge.
REQ-032 Reset asserted mid-period SHALL abort the period; no partial state SHALL survive.
REQ-033 After rst_n deasserts with enable=1, the behaviour SHALL be identical to an enable rise (REQ-026 to REQ-028).

Verification
REQ-034 PRESCALE=1, SLEW_STEP=0, enable=1, duty_in=128 -> duty_active=128 after the first B; thereafter pwm_out high 128 clk and low 127 clk per 255-clk period; period_start every 255 clk.
REQ-035 PRESCALE=4, SLEW_STEP=8, duty_in=40 from reset -> duty_active reads 8, 16, 24, 32, 40 after successive boundaries spaced 1020 clk, then stays 40; then duty_in=0 -> 32, 24, 16, 8, 0.
REQ-036 SLEW_STEP=0, duty_in=255 -> pwm_out constantly 1 after the first B; duty_in=0 -> pwm_out constantly 0 after the next B.
REQ-037 duty_active=100, duty_in changed to 200 at cnt=50 -> pwm_out width stays 100 counts for the current period; duty_active=200 only after B.
REQ-038 enable dropped at cnt=120 with duty_active=100 -> pwm_out=0 next edge; cnt=0, duty_active=0; on re-enable, period_start pulses after 1 clk and the first period is all low.
REQ-039 rst_n pulsed low at cnt=200 -> all outputs 0 asynchronously; after release, behaviour matches REQ-034 from cnt=0.
